// File: rtl/mmap_host.sv
// Host-side initiator for the byte-serial memory-map protocol: serializes command,
// count, address and write data to the UART tx, reassembles read words from UART rx.
module mmap_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_start,
  input  logic        h_write,
  input  logic        h_incr,
  input  logic [5:0]  h_cmd,
  input  logic [15:0] h_count,
  input  logic [31:0] h_address,
  input  logic [31:0] h_wdata,
  input  logic        h_wvalid,
  output logic        h_wready,
  output logic [31:0] h_rdata,
  output logic        h_rvalid,
  output logic        h_busy,
  output logic        h_done,
  output logic        h_error,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WGET,
    S_WSEND,
    S_RDATA,
    S_FIN
  } state_t;

  localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic        r_incr;
  logic [5:0]  r_cmd;
  logic [15:0] r_count;
  logic [31:0] r_addr;
  logic [2:0]  r_hidx;
  logic [1:0]  r_widx;
  logic [16:0] r_words;
  logic [31:0] r_wword;
  logic [23:0] r_shift;
  logic [1:0]  r_ridx;
  logic        r_rd_last;
  logic [31:0] r_tout;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_strobe_d;

  logic        w_sending;
  logic        w_strobe;
  logic        w_last_word;
  logic        w_rx_take;
  logic        w_abort;
  logic [7:0]  w_tx_byte;

  // Strobe is combinational so the command byte can launch in the first HDR cycle;
  // the registered copy enforces the one-idle-cycle gap between launches.
  assign w_sending   = (r_state == S_HDR) || (r_state == S_WSEND);
  assign w_strobe    = w_sending && !tx_busy && !r_strobe_d;
  assign w_last_word = (r_words == {1'b0, r_count});
  assign w_rx_take   = (r_state == S_RDATA) && new_rx_data && !r_rd_last;
  assign w_abort     = (r_state == S_RDATA) && !new_rx_data && !r_rd_last &&
                       (r_tout == TOUT_LAST);

  always_comb begin
    w_tx_byte = '0;
    if (r_state == S_HDR) begin
      case (r_hidx)
        3'd0:    w_tx_byte = {r_write, r_incr, r_cmd};
        3'd1:    w_tx_byte = r_count[15:8];
        3'd2:    w_tx_byte = r_count[7:0];
        3'd3:    w_tx_byte = r_addr[31:24];
        3'd4:    w_tx_byte = r_addr[23:16];
        3'd5:    w_tx_byte = r_addr[15:8];
        default: w_tx_byte = r_addr[7:0];
      endcase
    end else if (r_state == S_WSEND) begin
      case (r_widx)
        2'd0:    w_tx_byte = r_wword[31:24];
        2'd1:    w_tx_byte = r_wword[23:16];
        2'd2:    w_tx_byte = r_wword[15:8];
        default: w_tx_byte = r_wword[7:0];
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (h_start) w_next = S_HDR;
      S_HDR:   if (w_strobe && (r_hidx == 3'd6)) w_next = r_write ? S_WGET : S_RDATA;
      S_WGET:  if (h_wvalid) w_next = S_WSEND;
      S_WSEND: if (w_strobe && (r_widx == 2'd3)) w_next = w_last_word ? S_FIN : S_WGET;
      S_RDATA: begin
        if (r_rd_last) w_next = S_FIN;
        else if (w_abort) w_next = S_IDLE;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write    <= 1'b0;
      r_incr     <= 1'b0;
      r_cmd      <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_hidx     <= '0;
      r_widx     <= '0;
      r_words    <= '0;
      r_wword    <= '0;
      r_shift    <= '0;
      r_ridx     <= '0;
      r_rd_last  <= 1'b0;
      r_tout     <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_strobe_d <= 1'b0;
    end else begin
      r_rvalid   <= 1'b0;
      r_strobe_d <= w_strobe;
      case (r_state)
        S_IDLE: begin
          if (h_start) begin
            r_write   <= h_write;
            r_incr    <= h_incr;
            r_cmd     <= h_cmd;
            r_count   <= h_count;
            r_addr    <= h_address;
            r_hidx    <= '0;
            r_widx    <= '0;
            r_words   <= '0;
            r_ridx    <= '0;
            r_rd_last <= 1'b0;
            r_tout    <= '0;
          end
        end
        S_HDR: begin
          if (w_strobe) r_hidx <= r_hidx + 3'd1;
        end
        S_WGET: begin
          if (h_wvalid) begin
            r_wword <= h_wdata;
            r_widx  <= '0;
          end
        end
        S_WSEND: begin
          if (w_strobe) begin
            r_widx <= r_widx + 2'd1;
            if ((r_widx == 2'd3) && !w_last_word) r_words <= r_words + 17'd1;
          end
        end
        S_RDATA: begin
          if (w_rx_take) begin
            r_shift <= {r_shift[15:0], rx_data};
            r_ridx  <= r_ridx + 2'd1;
            r_tout  <= '0;
            if (r_ridx == 2'd3) begin
              r_rdata  <= {r_shift, rx_data};
              r_rvalid <= 1'b1;
              if (w_last_word) r_rd_last <= 1'b1;
              else             r_words   <= r_words + 17'd1;
            end
          end else if (!r_rd_last) begin
            r_tout <= r_tout + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Timeout aborts straight from RDATA so done/error land exactly on the expiring cycle.
  assign h_wready    = (r_state == S_WGET);
  assign h_busy      = (r_state != S_IDLE) && (r_state != S_FIN) && !w_abort;
  assign h_done      = (r_state == S_FIN) || w_abort;
  assign h_error     = w_abort;
  assign h_rdata     = r_rdata;
  assign h_rvalid    = r_rvalid;
  assign tx_data     = w_tx_byte;
  assign new_tx_data = w_strobe;

endmodule

// File: tb/tb_mmap_host.sv
// Scoreboard bench for mmap_host: drivers push expected tx bytes, read words and
// done/error events; a negedge monitor pops and compares as the DUT presents them.
module tb_mmap_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_start, h_write, h_incr;
  logic [5:0]  h_cmd;
  logic [15:0] h_count;
  logic [31:0] h_address, h_wdata;
  logic        h_wvalid, h_wready;
  logic [31:0] h_rdata;
  logic        h_rvalid, h_busy, h_done, h_error;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        new_rx_data;

  mmap_host #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst),
    .h_start(h_start), .h_write(h_write), .h_incr(h_incr), .h_cmd(h_cmd),
    .h_count(h_count), .h_address(h_address), .h_wdata(h_wdata),
    .h_wvalid(h_wvalid), .h_wready(h_wready), .h_rdata(h_rdata),
    .h_rvalid(h_rvalid), .h_busy(h_busy), .h_done(h_done), .h_error(h_error),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .rx_data(rx_data), .new_rx_data(new_rx_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_seen = 0;
  int wr_hs = 0;
  int last_rx_cyc = 0;
  int busy_cnt = 0;
  bit stall_en = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd[$];
  bit          exp_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: optionally busy for 3 cycles after each launch.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (new_tx_data && stall_en) busy_cnt = 3;
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (new_tx_data) begin
      logic [7:0] e;
      checks++;
      tx_seen++;
      if (tx_busy) begin
        errors++;
        $display("FAIL strobe_while_busy: tx_data=%02h sent while tx_busy=1", tx_data);
      end else if (h_wready) begin
        errors++;
        $display("FAIL wready_tx_overlap: h_wready=1 with new_tx_data=1");
      end else if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx: got %02h, expected no byte", tx_data);
      end else begin
        e = exp_tx.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_byte #%0d: got %02h, expected %02h", tx_seen, tx_data, e);
        end
      end
    end
    if (h_wready && h_wvalid) wr_hs++;
    if (new_rx_data) last_rx_cyc = cyc;
    if (h_rvalid) begin
      logic [31:0] w;
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: h_rdata=%08h, expected no read word", h_rdata);
      end else begin
        w = exp_rd.pop_front();
        if (h_rdata !== w) begin
          errors++;
          $display("FAIL rdata: got %08h, expected %08h", h_rdata, w);
        end
      end
    end
    if (h_done) begin
      bit ee;
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: h_done=1 h_error=%0b, expected none", h_error);
      end else begin
        ee = exp_done.pop_front();
        if (h_error !== ee || h_busy !== 1'b0) begin
          errors++;
          $display("FAIL done_flags: h_error=%0b h_busy=%0b, expected h_error=%0b h_busy=0",
                   h_error, h_busy, ee);
        end else if (ee && (cyc - last_rx_cyc) != 20) begin
          errors++;
          $display("FAIL timeout_latency: got %0d cycles, expected 20", cyc - last_rx_cyc);
        end
      end
    end else if (h_error) begin
      checks++;
      errors++;
      $display("FAIL error_without_done: h_error=1 h_done=0, expected h_error only with h_done");
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic start_txn(input logic w, input logic inc, input logic [5:0] cmd,
                           input logic [15:0] cnt, input logic [31:0] addr);
    exp_tx.push_back({w, inc, cmd});
    exp_tx.push_back(cnt[15:8]);
    exp_tx.push_back(cnt[7:0]);
    exp_tx.push_back(addr[31:24]);
    exp_tx.push_back(addr[23:16]);
    exp_tx.push_back(addr[15:8]);
    exp_tx.push_back(addr[7:0]);
    h_write = w; h_incr = inc; h_cmd = cmd; h_count = cnt; h_address = addr;
    h_start = 1'b1;
    tick();
    h_start = 1'b0;
    check("busy_after_start", 64'(h_busy), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int dly);
    int n = 0;
    while (!h_wready && n < 500) begin
      tick();
      n++;
    end
    if (!h_wready) begin
      checks++;
      errors++;
      $display("FAIL wready_wait: h_wready=0 after %0d cycles, expected 1", n);
      return;
    end
    repeat (dly) tick();
    exp_tx.push_back(w[31:24]);
    exp_tx.push_back(w[23:16]);
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
    h_wdata = w;
    h_wvalid = 1'b1;
    tick();
    h_wvalid = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_seen < target && n < 500) begin
      tick();
      n++;
    end
    if (tx_seen < target) begin
      checks++;
      errors++;
      $display("FAIL tx_wait: saw %0d bytes, expected %0d", tx_seen, target);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
    tick();
  endtask

  task automatic send_rx_word(input logic [31:0] w);
    exp_rd.push_back(w);
    send_rx(w[31:24]);
    send_rx(w[23:16]);
    send_rx(w[15:8]);
    send_rx(w[7:0]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_done.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, 64'(exp_done.size()), 64'd0);
    check({name, "_tx_left"}, 64'(exp_tx.size()), 64'd0);
    check({name, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
    exp_done.delete();
    exp_tx.delete();
    exp_rd.delete();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    h_start = 0; h_write = 0; h_incr = 0; h_cmd = '0; h_count = '0;
    h_address = '0; h_wdata = '0; h_wvalid = 0; rx_data = '0; new_rx_data = 0;
    repeat (3) tick();
    check("reset_outputs",
          64'({h_wready, h_rdata, h_rvalid, h_busy, h_done, h_error, tx_data, new_tx_data}),
          64'd0);
    rst = 1'b1;
    tick();

    // Single-word write
    exp_done.push_back(1'b0);
    start_txn(1'b1, 1'b1, 6'd0, 16'd0, 32'h0000_0001);
    send_word(32'h7F7F_7F7F, 0);
    wait_done("wr1");

    // Single-word read
    exp_done.push_back(1'b0);
    tx_seen = 0;
    start_txn(1'b0, 1'b0, 6'd1, 16'd0, 32'h1010_1010);
    wait_tx(7);
    send_rx_word(32'hAAAA_AAAA);
    wait_done("rd1");

    // Two-word write with wvalid delay and tx_busy stalls
    exp_done.push_back(1'b0);
    stall_en = 1;
    wr_hs = 0;
    start_txn(1'b1, 1'b0, 6'h3F, 16'd1, 32'h89AB_CDEF);
    send_word(32'h1122_3344, 5);
    send_word(32'h5566_7788, 5);
    wait_done("wr2");
    check("wready_handshakes", 64'(wr_hs), 64'd2);
    stall_en = 0;
    repeat (5) tick();

    // Two-word read
    exp_done.push_back(1'b0);
    tx_seen = 0;
    start_txn(1'b0, 1'b1, 6'h2A, 16'd1, 32'h0000_0400);
    wait_tx(7);
    send_rx_word(32'h0102_0304);
    send_rx_word(32'hF0E0_D0C0);
    wait_done("rd2");

    // Read timeout after two bytes; partial word discarded
    exp_done.push_back(1'b1);
    tx_seen = 0;
    start_txn(1'b0, 1'b0, 6'd1, 16'd0, 32'h2000_0000);
    wait_tx(7);
    send_rx(8'h12);
    send_rx(8'h34);
    wait_done("tout");

    // Normal read after timeout
    exp_done.push_back(1'b0);
    tx_seen = 0;
    start_txn(1'b0, 1'b0, 6'd4, 16'd0, 32'h3000_0004);
    wait_tx(7);
    send_rx_word(32'hCAFE_BABE);
    wait_done("rd3");

    // rx bytes while idle are ignored
    send_rx(8'h55);
    send_rx(8'h66);
    check("idle_rx_busy", 64'(h_busy), 64'd0);

    // Reset mid-write after the 4th tx byte
    tx_seen = 0;
    exp_done.push_back(1'b0);
    start_txn(1'b1, 1'b0, 6'd5, 16'd0, 32'hA5A5_A5A5);
    wait_tx(4);
    exp_tx.delete();
    exp_done.delete();
    rst = 1'b0;
    #1;
    check("reset_mid_outputs",
          64'({h_wready, h_rdata, h_rvalid, h_busy, h_done, h_error, tx_data, new_tx_data}),
          64'd0);
    repeat (4) tick();
    rst = 1'b1;
    repeat (4) tick();
    check("after_reset_idle", 64'({h_busy, h_wready}), 64'd0);
    check("after_reset_tx_count", 64'(tx_seen), 64'd4);

    // Start while busy is ignored
    exp_done.push_back(1'b0);
    start_txn(1'b1, 1'b1, 6'd2, 16'd0, 32'h1234_5678);
    tick();
    h_address = 32'hCAFE_F00D;
    h_count = 16'd5;
    h_start = 1'b1;
    tick();
    h_start = 1'b0;
    check("busy_during_restart", 64'(h_busy), 64'd1);
    send_word(32'hDEAD_BEEF, 0);
    wait_done("busy_start");

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
